// File: rtl/multi_channel_clock_gen.sv
// Multi-channel divided clock generator. Each channel divides clk_base by a
// programmable period with a programmable high time. Period and high time are
// captured into shadow registers only at a period boundary, so reprogramming
// never produces runt pulses. A shared sync input restarts all running channels.
module multi_channel_clock_gen #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                      clk_base,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] period,
    input  logic [CHANNELS*WIDTH-1:0] high_time,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       period_start,
    output logic [CHANNELS-1:0]       busy
);

    typedef enum logic {StIdle, StRun} state_e;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        state_e           r_state, w_state_nxt;
        logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
        logic [WIDTH-1:0] r_per_sh, w_per_sh_nxt;
        logic [WIDTH-1:0] r_hi_sh, w_hi_sh_nxt;
        logic             r_clk, w_clk_nxt;
        logic             r_ps, w_ps_nxt;
        logic             w_restart;
        logic [WIDTH-1:0] w_period;
        logic [WIDTH-1:0] w_high;
        logic [WIDTH-1:0] w_cnt_inc;

        assign w_period  = period[gi*WIDTH +: WIDTH];
        assign w_high    = high_time[gi*WIDTH +: WIDTH];
        // cnt stays below per_sh on this path, so the increment cannot wrap
        assign w_cnt_inc = r_cnt + 1'b1;

        // Next-state logic: start, count, boundary reload, graceful stop and sync
        always_comb begin
            w_state_nxt  = r_state;
            w_cnt_nxt    = r_cnt;
            w_per_sh_nxt = r_per_sh;
            w_hi_sh_nxt  = r_hi_sh;
            w_clk_nxt    = r_clk;
            w_ps_nxt     = 1'b0;
            w_restart    = 1'b0;

            unique case (r_state)
                StIdle: begin
                    w_clk_nxt = 1'b0;
                    if (en[gi]) begin
                        w_state_nxt = StRun;
                        w_restart   = 1'b1;
                    end
                end
                StRun: begin
                    // sync acts as an early boundary; a disabled channel stops on it
                    if (sync || (r_cnt == r_per_sh)) begin
                        if (en[gi]) begin
                            w_restart = 1'b1;
                        end else begin
                            w_state_nxt = StIdle;
                            w_clk_nxt   = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        w_clk_nxt = (w_cnt_inc < r_hi_sh);
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                    w_clk_nxt   = 1'b0;
                end
            endcase

            if (w_restart) begin
                w_cnt_nxt    = '0;
                w_per_sh_nxt = w_period;
                w_hi_sh_nxt  = w_high;
                w_clk_nxt    = (w_high != '0);
                w_ps_nxt     = 1'b1;
            end
        end

        // State and registered outputs, cleared asynchronously by reset
        always_ff @(posedge clk_base or posedge reset) begin
            if (reset) begin
                r_state  <= StIdle;
                r_cnt    <= '0;
                r_per_sh <= '0;
                r_hi_sh  <= '0;
                r_clk    <= 1'b0;
                r_ps     <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_cnt    <= w_cnt_nxt;
                r_per_sh <= w_per_sh_nxt;
                r_hi_sh  <= w_hi_sh_nxt;
                r_clk    <= w_clk_nxt;
                r_ps     <= w_ps_nxt;
            end
        end

        assign clk_out[gi]      = r_clk;
        assign period_start[gi] = r_ps;
        assign busy[gi]         = (r_state == StRun);
    end

endmodule

// File: tb/tb_multi_channel_clock_gen.sv
// Self-checking bench for multi_channel_clock_gen. Expected per-cycle output
// vectors are pushed into a scoreboard queue when stimulus is set up and popped
// one per clock edge, sampled 1 time unit after the rising edge.
module tb_multi_channel_clock_gen;

    localparam int unsigned W  = 16;
    localparam int unsigned CH = 2;

    typedef struct {
        logic [CH-1:0] clk;
        logic [CH-1:0] ps;
        logic [CH-1:0] busy;
    } exp_t;

    logic              clk_base;
    logic              reset;
    logic [CH-1:0]     en;
    logic [CH*W-1:0]   period;
    logic [CH*W-1:0]   high_time;
    logic              sync;
    logic [CH-1:0]     clk_out;
    logic [CH-1:0]     period_start;
    logic [CH-1:0]     busy;

    exp_t sb_q[$];
    int   total;
    int   bad;

    multi_channel_clock_gen #(
        .WIDTH    (W),
        .CHANNELS (CH)
    ) dut (
        .clk_base     (clk_base),
        .reset        (reset),
        .en           (en),
        .period       (period),
        .high_time    (high_time),
        .sync         (sync),
        .clk_out      (clk_out),
        .period_start (period_start),
        .busy         (busy)
    );

    initial clk_base = 1'b0;
    always #5 clk_base = ~clk_base;

    task automatic push(input logic [CH-1:0] c, input logic [CH-1:0] p, input logic [CH-1:0] b);
        exp_t e;
        e.clk  = c;
        e.ps   = p;
        e.busy = b;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_base);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        en        = '0;
        period    = '0;
        high_time = '0;
        sync      = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset     = 1'b1;
        en        = '0;
        period    = '0;
        high_time = '0;
        sync      = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) push(2'b00, 2'b00, 2'b00);
        // en raised while reset is held must have no effect
        en = 2'b11;
        for (int i = 0; sb_q.size() > 0; i++) begin
            step();
            e = sb_q.pop_front();
            total++;
            if ({clk_out, period_start, busy} !== {e.clk, e.ps, e.busy}) begin
                bad++;
                $display("FAIL reset[%0d]: clk/ps/busy got %b/%b/%b want %b/%b/%b", i,
                         clk_out, period_start, busy, e.clk, e.ps, e.busy);
            end
        end
        en    = '0;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        period[0*W +: W]    = 16'd4;
        high_time[0*W +: W] = 16'd2;
        en = 2'b01;
        for (int r = 0; r < 2; r++) begin
            push(2'b01, 2'b01, 2'b01);
            push(2'b01, 2'b00, 2'b01);
            push(2'b00, 2'b00, 2'b01);
            push(2'b00, 2'b00, 2'b01);
            push(2'b00, 2'b00, 2'b01);
        end
        for (int i = 0; sb_q.size() > 0; i++) begin
            step();
            e = sb_q.pop_front();
            total++;
            if ({clk_out, period_start, busy} !== {e.clk, e.ps, e.busy}) begin
                bad++;
                $display("FAIL basic[%0d]: clk/ps/busy got %b/%b/%b want %b/%b/%b", i,
                         clk_out, period_start, busy, e.clk, e.ps, e.busy);
            end
        end
    endtask

    // Runs straight after test_basic: the next edge starts a new period
    task automatic test_reprogram();
        exp_t e;
        logic [CH-1:0] c[11] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
                                 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        logic [CH-1:0] p[11] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00,
                                 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        for (int k = 0; k < 11; k++) push(c[k], p[k], 2'b01);
        for (int i = 0; sb_q.size() > 0; i++) begin
            step();
            // reprogram mid-period, after cnt=1 has been observed
            if (i == 1) begin
                period[0*W +: W]    = 16'd2;
                high_time[0*W +: W] = 16'd1;
            end
            e = sb_q.pop_front();
            total++;
            if ({clk_out, period_start, busy} !== {e.clk, e.ps, e.busy}) begin
                bad++;
                $display("FAIL reprogram[%0d]: clk/ps/busy got %b/%b/%b want %b/%b/%b", i,
                         clk_out, period_start, busy, e.clk, e.ps, e.busy);
            end
        end
    endtask

    task automatic test_disable();
        exp_t e;
        logic [CH-1:0] c[7] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [CH-1:0] p[7] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [CH-1:0] b[7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        do_reset();
        period[0*W +: W]    = 16'd4;
        high_time[0*W +: W] = 16'd2;
        en = 2'b01;
        for (int k = 0; k < 7; k++) push(c[k], p[k], b[k]);
        for (int i = 0; sb_q.size() > 0; i++) begin
            step();
            if (i == 1) en = 2'b00;
            e = sb_q.pop_front();
            total++;
            if ({clk_out, period_start, busy} !== {e.clk, e.ps, e.busy}) begin
                bad++;
                $display("FAIL disable[%0d]: clk/ps/busy got %b/%b/%b want %b/%b/%b", i,
                         clk_out, period_start, busy, e.clk, e.ps, e.busy);
            end
        end
    endtask

    task automatic test_sync();
        exp_t e;
        logic [CH-1:0] c[10] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11,
                                 2'b10, 2'b00, 2'b01, 2'b01, 2'b10};
        logic [CH-1:0] p[10] = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b00,
                                 2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
        do_reset();
        period[0*W +: W]    = 16'd3;
        high_time[0*W +: W] = 16'd2;
        period[1*W +: W]    = 16'd5;
        high_time[1*W +: W] = 16'd3;
        en = 2'b11;
        for (int k = 0; k < 10; k++) push(c[k], p[k], 2'b11);
        for (int i = 0; sb_q.size() > 0; i++) begin
            step();
            sync = (i == 2);
            e = sb_q.pop_front();
            total++;
            if ({clk_out, period_start, busy} !== {e.clk, e.ps, e.busy}) begin
                bad++;
                $display("FAIL sync[%0d]: clk/ps/busy got %b/%b/%b want %b/%b/%b", i,
                         clk_out, period_start, busy, e.clk, e.ps, e.busy);
            end
        end
        sync = 1'b0;
    endtask

    task automatic test_edges();
        exp_t e;
        do_reset();
        // ch0: high_time 0 -> always low; ch1: high_time > period -> always high
        period[0*W +: W]    = 16'd3;
        high_time[0*W +: W] = 16'd0;
        period[1*W +: W]    = 16'd4;
        high_time[1*W +: W] = 16'd9;
        en = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            push(2'b10, {(k == 1 || k == 6), (k == 1 || k == 5)}, 2'b11);
        end
        for (int i = 0; sb_q.size() > 0; i++) begin
            step();
            e = sb_q.pop_front();
            total++;
            if ({clk_out, period_start, busy} !== {e.clk, e.ps, e.busy}) begin
                bad++;
                $display("FAIL duty[%0d]: clk/ps/busy got %b/%b/%b want %b/%b/%b", i,
                         clk_out, period_start, busy, e.clk, e.ps, e.busy);
            end
        end
        do_reset();
        // period 0: one-cycle period, period_start stays high
        period[0*W +: W]    = 16'd0;
        high_time[0*W +: W] = 16'd1;
        en = 2'b01;
        for (int k = 0; k < 4; k++) push(2'b01, 2'b01, 2'b01);
        for (int i = 0; sb_q.size() > 0; i++) begin
            step();
            e = sb_q.pop_front();
            total++;
            if ({clk_out, period_start, busy} !== {e.clk, e.ps, e.busy}) begin
                bad++;
                $display("FAIL period0[%0d]: clk/ps/busy got %b/%b/%b want %b/%b/%b", i,
                         clk_out, period_start, busy, e.clk, e.ps, e.busy);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        period[0*W +: W]    = 16'd4;
        high_time[0*W +: W] = 16'd2;
        en = 2'b01;
        step();
        total++;
        if ({clk_out, period_start, busy} !== {2'b01, 2'b01, 2'b01}) begin
            bad++;
            $display("FAIL async_pre: clk/ps/busy got %b/%b/%b want 01/01/01",
                     clk_out, period_start, busy);
        end
        // assert reset between edges and check outputs clear before any edge
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({clk_out, period_start, busy} !== {2'b00, 2'b00, 2'b00}) begin
            bad++;
            $display("FAIL async_clear: clk/ps/busy got %b/%b/%b want 00/00/00",
                     clk_out, period_start, busy);
        end
        step();
        reset = 1'b0;
        push(2'b01, 2'b01, 2'b01);
        push(2'b01, 2'b00, 2'b01);
        push(2'b00, 2'b00, 2'b01);
        for (int i = 0; sb_q.size() > 0; i++) begin
            step();
            e = sb_q.pop_front();
            total++;
            if ({clk_out, period_start, busy} !== {e.clk, e.ps, e.busy}) begin
                bad++;
                $display("FAIL async_restart[%0d]: clk/ps/busy got %b/%b/%b want %b/%b/%b", i,
                         clk_out, period_start, busy, e.clk, e.ps, e.busy);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_reprogram();
        test_disable();
        test_sync();
        test_edges();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
